add_sub_pipe: RTL and testbench



---
 rtl/add_sub_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_add_sub_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_pipe.sv
// Pipelined add/sub with carry-chain slices, valid/ready, tag, flags.
// ADD_SUB_PIPE_SAT_EN adds in_sat: per-op signed saturation on overflow.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input handshake
//   in_a, in_b           operands
//   in_sub               1 = A-B, 0 = A+B
//   in_tag               sideband tag, returned with the result
//   in_sat               clamp on overflow (only with ADD_SUB_PIPE_SAT_EN)
//   out_valid/out_ready  output handshake
//   out_result           sum/difference (or clamped value)
//   out_tag              tag of this result
//   out_carry            MSB carry out (sub: 1 = no borrow)
//   out_ovf              signed overflow
//   out_zero, out_neg    result == 0, result sign
module add_sub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
`ifdef ADD_SUB_PIPE_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int C = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  // rdy[k]: stage k can take a new entry this cycle
  logic [STAGES:0] rdy;

  // Stage inputs (from the port or previous stage register)
  logic             src_v   [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_r   [STAGES];
  logic             src_c   [STAGES];
  logic [TAG_W-1:0] src_tag [STAGES];

  // Combinational slice results
  logic [WIDTH-1:0] nxt_r [STAGES];
  logic             nxt_c [STAGES];

  // Stage register contents
  logic             q_v   [STAGES];
  logic [WIDTH-1:0] q_a   [STAGES];
  logic [WIDTH-1:0] q_b   [STAGES];
  logic [WIDTH-1:0] q_r   [STAGES];
  logic             q_c   [STAGES];
  logic [TAG_W-1:0] q_tag [STAGES];

`ifdef ADD_SUB_PIPE_SAT_EN
  logic src_s [STAGES];
  logic q_s   [STAGES];
`endif

  logic [WIDTH-1:0] fin_r;
  logic             fin_ovf;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_src
      assign src_v[k]   = in_valid;
      assign src_a[k]   = in_a;
      assign src_b[k]   = in_sub ? ~in_b : in_b;
      assign src_r[k]   = '0;
      assign src_c[k]   = in_sub;
      assign src_tag[k] = in_tag;
`ifdef ADD_SUB_PIPE_SAT_EN
      assign src_s[k]   = in_sat;
`endif
    end else begin : g_src
      assign src_v[k]   = q_v[k-1];
      assign src_a[k]   = q_a[k-1];
      assign src_b[k]   = q_b[k-1];
      assign src_r[k]   = q_r[k-1];
      assign src_c[k]   = q_c[k-1];
      assign src_tag[k] = q_tag[k-1];
`ifdef ADD_SUB_PIPE_SAT_EN
      assign src_s[k]   = q_s[k-1];
`endif
    end

    logic [C:0]       sum;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] ld_r;

    assign sum = {1'b0, src_a[k][k*C +: C]}
               + {1'b0, src_b[k][k*C +: C]}
               + {{C{1'b0}}, src_c[k]};

    always_comb begin
      r_n = src_r[k];
      r_n[k*C +: C] = sum[C-1:0];
    end

    assign nxt_r[k] = r_n;
    assign nxt_c[k] = sum[C];

    // Last stage stores the (possibly clamped) final value
    if (k == L) begin : g_ld
      assign ld_r = fin_r;
    end else begin : g_ld
      assign ld_r = r_n;
    end

    logic             v_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             c_q;
    logic [TAG_W-1:0] t_q;

    assign rdy[k] = !v_q || rdy[k+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        r_q <= '0;
        c_q <= 1'b0;
        t_q <= '0;
      end else if (rdy[k]) begin
        v_q <= src_v[k];
        if (src_v[k]) begin
          a_q <= src_a[k];
          b_q <= src_b[k];
          r_q <= ld_r;
          c_q <= sum[C];
          t_q <= src_tag[k];
        end
      end
    end

    assign q_v[k]   = v_q;
    assign q_a[k]   = a_q;
    assign q_b[k]   = b_q;
    assign q_r[k]   = r_q;
    assign q_c[k]   = c_q;
    assign q_tag[k] = t_q;

`ifdef ADD_SUB_PIPE_SAT_EN
    logic s_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= 1'b0;
      end else if (rdy[k] && src_v[k]) begin
        s_q <= src_s[k];
      end
    end

    assign q_s[k] = s_q;
`endif
  end

  // Overflow: operand signs agree but result sign differs
  assign fin_ovf = (src_a[L][WIDTH-1] == src_b[L][WIDTH-1])
                && (nxt_r[L][WIDTH-1] != src_a[L][WIDTH-1]);

  always_comb begin
    fin_r = nxt_r[L];
`ifdef ADD_SUB_PIPE_SAT_EN
    // Negative A can only overflow downward
    if (src_s[L] && fin_ovf) begin
      fin_r = src_a[L][WIDTH-1]
            ? {1'b1, {(WIDTH-1){1'b0}}}
            : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (rdy[L] && src_v[L]) begin
      ovf_q  <= fin_ovf;
      zero_q <= (fin_r == '0);
      neg_q  <= fin_r[WIDTH-1];
    end
  end

  assign out_valid  = q_v[L];
  assign out_result = q_r[L];
  assign out_tag    = q_tag[L];
  assign out_carry  = q_c[L];
  assign out_ovf    = ovf_q;
  assign out_zero   = zero_q;
  assign out_neg    = neg_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed bench for add_sub_pipe (WIDTH=32, STAGES=2, TAG_W=4).
// Drives on negedge, samples 1ns before posedge.
module tb_add_sub_pipe;

  localparam int W = 32;
  localparam int S = 2;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic [T-1:0] in_tag = '0;
`ifdef ADD_SUB_PIPE_SAT_EN
  logic         in_sat = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic [T-1:0] out_tag;
  logic         out_carry;
  logic         out_ovf;
  logic         out_zero;
  logic         out_neg;

  add_sub_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .in_tag     (in_tag),
`ifdef ADD_SUB_PIPE_SAT_EN
    .in_sat     (in_sat),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
    .out_neg    (out_neg)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_acc = 0;
  int cyc = 0;

  logic [W-1:0] q_res [$];
  logic [T-1:0] q_tag [$];
  int           q_cyc [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic sub);
    return sub ? a - b : a + b;
  endfunction

  // Output monitor: records transfers, checks hold while stalled
  logic [39:0] held;
  logic [39:0] pk;
  logic        held_v = 1'b0;

  always begin
    @(negedge clk);
    #4;
    cyc++;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      pk = {out_result, out_tag, out_carry, out_ovf, out_zero, out_neg};
      if (held_v) chk("hold", {23'd0, out_valid, pk}, {23'd0, 1'b1, held});
      held_v = out_valid && !out_ready;
      held = pk;
      if (out_valid && out_ready) begin
        q_res.push_back(out_result);
        q_tag.push_back(out_tag);
        q_cyc.push_back(cyc);
      end
    end
  end

  // Called on a negedge; returns on the negedge after acceptance
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic [T-1:0] tag);
    bit acc;
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_tag = tag;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      #4;
      acc = in_ready;
      @(negedge clk);
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    else n_acc++;
  endtask

  task automatic run1(input string nm, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic sub,
                      input logic [T-1:0] tag, input logic [W-1:0] er,
                      input logic [3:0] ef);
    int lat;
    send(a, b, sub, tag);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(S));
    chk({nm, "_res"}, 64'(out_result), 64'(er));
    chk({nm, "_cozn"},
        {60'd0, out_carry, out_ovf, out_zero, out_neg}, {60'd0, ef});
    chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out",
        {23'd0, out_valid, out_result, out_tag,
         out_carry, out_ovf, out_zero, out_neg}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    //            a             b             sub  tag  result        cozn
    run1("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0, 4'd3, 32'h80000000, 4'b0101);
    run1("sub_neg", 32'h00000005, 32'h00000007, 1'b1, 4'd1, 32'hFFFFFFFE, 4'b0001);
    run1("sub_eq",  32'h00000007, 32'h00000007, 1'b1, 4'd2, 32'h00000000, 4'b1010);
    run1("ovf_neg", 32'h80000000, 32'h00000001, 1'b1, 4'd4, 32'h7FFFFFFF, 4'b1100);
    run1("zero_z",  32'h00000000, 32'h00000000, 1'b1, 4'd5, 32'h00000000, 4'b1010);
    run1("wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 4'd6, 32'h00000000, 4'b1010);
    run1("slice_c", 32'h0000FFFF, 32'h00000001, 1'b0, 4'd7, 32'h00010000, 4'b0000);
    run1("min_min", 32'h80000000, 32'h80000000, 1'b0, 4'd8, 32'h00000000, 4'b1110);

    // Back-to-back stream
    q_res.delete(); q_tag.delete(); q_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      send(iv * 32'h11111111, 32'h0F0F0F0F + iv, iv[0], iv[3:0]);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("strm_cnt", 64'(q_res.size()), 64'd8);
    for (int j = 0; j < 8 && j < q_res.size(); j++) begin
      logic [31:0] jv;
      jv = 32'(j);
      chk($sformatf("strm_res%0d", j), 64'(q_res[j]),
          64'(model(jv * 32'h11111111, 32'h0F0F0F0F + jv, jv[0])));
      chk($sformatf("strm_tag%0d", j), 64'(q_tag[j]), 64'(jv[3:0]));
      chk($sformatf("strm_cyc%0d", j), 64'(q_cyc[j] - q_cyc[0]), 64'(j));
    end

    // Backpressure
    q_res.delete(); q_tag.delete(); q_cyc.delete();
    n_acc = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [31:0] iv;
          iv = 32'(i);
          send(32'h40000000 + iv, iv << 8, 1'b1, 4'(iv + 8));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        #1;
        chk("stall_acc", 64'(n_acc), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    chk("stall_cnt", 64'(q_res.size()), 64'd6);
    for (int j = 0; j < 6 && j < q_res.size(); j++) begin
      logic [31:0] jv;
      jv = 32'(j);
      chk($sformatf("stall_res%0d", j), 64'(q_res[j]),
          64'(model(32'h40000000 + jv, jv << 8, 1'b1)));
      chk($sformatf("stall_tag%0d", j), 64'(q_tag[j]), 64'(4'(jv + 8)));
    end

    // Reset with two ops in flight
    send(32'h00001234, 32'h00001111, 1'b0, 4'd5);
    send(32'h0000ABCD, 32'h00000001, 1'b1, 4'd6);
    in_valid = 1'b0;
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out",
        {23'd0, out_valid, out_result, out_tag,
         out_carry, out_ovf, out_zero, out_neg}, 64'd0);
    chk("rst_mid_ready", 64'(in_ready), 64'd1);
    q_res.delete(); q_tag.delete(); q_cyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_stale", 64'(q_res.size()), 64'd0);
    chk("rst_valid_low", 64'(out_valid), 64'd0);
    run1("post_rst", 32'h00000010, 32'h00000020, 1'b0, 4'd9, 32'h00000030, 4'b0000);

`ifdef ADD_SUB_PIPE_SAT_EN
    in_sat = 1'b1;
    run1("sat_neg", 32'h80000000, 32'h00000001, 1'b1, 4'd10, 32'h80000000, 4'b1101);
    run1("sat_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0, 4'd11, 32'h7FFFFFFF, 4'b0100);
    in_sat = 1'b0;
    run1("nosat_neg", 32'h80000000, 32'h00000001, 1'b1, 4'd12, 32'h7FFFFFFF, 4'b1100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
